jt89_cmd_writer: RTL and testbench
==================================

# jt89_cmd_writer

Bus-side initiator for the jt89 PSG write port. Accepts high-level commands (tone period, attenuation, noise control) on a valid/ready interface and serialises them into SN76489-format byte writes on a `wr_n`/`dout` pair. The PSG latches a byte on a `wr_n` falling edge. The block sits between the sound CPU glue, or a test sequencer, and the jt89 `wr_n`/`din` inputs, on the same clock.

## Interface
Parameters:
- `WR_LOW`, 1, cycles `wr_n` is held low per byte (1..15).
- `WR_HIGH`, 1, cycles `wr_n` is held high after each byte before the next byte or idle (1..15).

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept; a command is accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_kind` in 2: 0 = tone, 1 = volume, 2 = noise, 3 = reserved.
- `cmd_ch` in 2: channel 0..3. Tone accepts 0..2. Volume accepts 0..3, where 3 is the noise attenuator. Noise ignores this field.
- `cmd_data` in 10: tone uses [9:0], volume uses [3:0], noise uses [2:0]. Unused bits are ignored.
- `wr_n` out 1: write strobe to the PSG, active low.
- `dout` out 8: byte to the PSG.
- `busy` out 1: equals `~cmd_ready`.
- `err` out 1: one-cycle pulse when an illegal command is accepted and dropped.

## Operation
- Byte encodings:
  - Tone latch byte: `{1, ch, 0, data[3:0]}`.
  - Tone data byte: `{0, 0, data[9:4]}`.
  - Volume byte: `{1, ch, 1, data[3:0]}`.
  - Noise byte: `{1, 1, 1, 0, 0, data[2:0]}`.
- Tone commands emit two bytes, latch byte then data byte. Volume and noise commands emit one byte.
- Illegal commands are accepted, emit no byte, and pulse `err` in the following cycle. A command is illegal if `cmd_kind` = 3, or if `cmd_kind` = tone with `cmd_ch` = 3.
- FSM states:
  - IDLE: `cmd_ready` = 1.
  - LOW1: `wr_n` = 0.
  - HIGH1: `wr_n` = 1.
  - LOW2: `wr_n` = 0.
  - HIGH2: `wr_n` = 1.
- FSM transitions:
  - IDLE → LOW1 on accept of an emitting command.
  - LOW1 → HIGH1 after `WR_LOW` cycles.
  - HIGH1 → LOW2 after `WR_HIGH` cycles if a data byte is pending, otherwise HIGH1 → IDLE.
  - LOW2 → HIGH2 after `WR_LOW` cycles.
  - HIGH2 → IDLE after `WR_HIGH` cycles.
- The command is registered on accept. `cmd_*` inputs may change freely after the accept edge.
- `dout` changes only on entry to LOW1 or LOW2. It is stable for the whole low phase and the following high phase.

## Timing
- Reset values: `wr_n` = 1, `dout` = 0x00, `cmd_ready` = 1, `busy` = 0, `err` = 0. State is IDLE and the phase counter is 0.
- If the accept happens at edge t, then `wr_n` falls at t+1, with `dout` valid in the same cycle.
- Single byte:
  - `wr_n` rises at t+1+`WR_LOW`.
  - `cmd_ready` returns at t+1+`WR_LOW`+`WR_HIGH`.
- Tone command: the second falling edge is at t+1+`WR_LOW`+`WR_HIGH`, and `cmd_ready` returns at t+1+2·(`WR_LOW`+`WR_HIGH`).
- Maximum throughput is one single-byte command every 1+`WR_LOW`+`WR_HIGH` cycles. `cmd_ready` is never high outside IDLE.
- Dropped commands (illegal, or redundant under shadow) return `cmd_ready` at t+1 and leave `wr_n` high.
- Reset mid-operation: at the next edge `wr_n` = 1, `dout` = 0, state is IDLE, and the pending byte is discarded. The PSG is reset by the same `rst`.

## Configuration
`JT89_CMD_SHADOW_EN`

With the macro defined, shadow registers track the PSG state:
- Shadow reset values match the PSG: tones = 0, volumes = 0xF, ctrl3 = 3'b100.
- A tone command identical to its shadow is dropped.
- A tone command whose [9:4] equals the shadow emits only the latch byte.
- A volume command equal to its shadow is dropped.
- Noise commands are never dropped, because every noise write clears the LFSR.
- Shadows update on accept.

Without the macro, every legal command emits its full byte sequence and no shadow state exists.

## Structure
- Shared package `jt89_cmd_pkg`:
  - `cmd_kind` encodings (KIND_TONE/VOL/NOISE).
  - Byte-header constants (latch bit, noise register code 3'b110).
  - FSM state enum.
- Sub-module `jt89_wr_strobe` contains the phase counter and the `wr_n` generator:
  - Inputs: `start`, `more`.
  - Outputs: `wr_n`, `phase_done`, `idle`.
- The top-level module holds the command register, byte encoder and optional shadows.

## Test plan
- Tone, ch1, data 0x2A5, defaults → `dout` 0xA5 then 0x2A, two `wr_n` falls 2 cycles apart, `cmd_ready` back 5 cycles after accept.
- Volume, ch2, data 0x5, then noise, data 0x5, back-to-back `cmd_valid` → bytes 0xD5 and 0xE5, accepts 3 cycles apart.
- `WR_LOW`=3, `WR_HIGH`=2, volume ch0 data 0x0 → `wr_n` low exactly 3 cycles, 0x90 stable throughout, `cmd_ready` back at t+6.
- Tone ch3 or `cmd_kind` 3 → `err` pulse at t+1, `wr_n` stays 1, `cmd_ready` back at t+1.
- Shadow build:
  - After reset, volume ch0 data 0xF is dropped.
  - Tone ch1 0x2A5 then tone ch1 0x2A7 → the second command emits only 0xA7.
  - Noise 0x4 repeated twice → 0xE4 is written both times.
- `rst` asserted during LOW2 of a tone command → next cycle `wr_n` = 1, `dout` = 0, `cmd_ready` = 1, and no further falling edge.

Source files
------------

// File: rtl/jt89_cmd_pkg.sv
// Shared definitions for the jt89 command writer: command kinds, byte headers, FSM codes, byte encoder.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package jt89_cmd_pkg;

    // cmd_kind encodings
    localparam logic [1:0] KIND_TONE  = 2'd0;
    localparam logic [1:0] KIND_VOL   = 2'd1;
    localparam logic [1:0] KIND_NOISE = 2'd2;
    localparam logic [1:0] KIND_RSVD  = 2'd3;

    // SN76489 byte header fields
    localparam logic       LATCH_BIT = 1'b1;
    localparam logic [2:0] REG_NOISE = 3'b110;

    // Strobe FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOW1  = 3'd1;
    localparam logic [2:0] ST_HIGH1 = 3'd2;
    localparam logic [2:0] ST_LOW2  = 3'd3;
    localparam logic [2:0] ST_HIGH2 = 3'd4;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] ch;
        logic [9:0] data;
    } cmd_t;

    // First byte is the latch/volume/noise byte; second is the tone high-bits data byte.
    function automatic logic [7:0] enc_byte(input cmd_t c, input logic second);
        logic [7:0] b;
        b = 8'h00;
        if (second) begin
            b = {2'b00, c.data[9:4]};
        end else begin
            case (c.kind)
                KIND_TONE:  b = {LATCH_BIT, c.ch, 1'b0, c.data[3:0]};
                KIND_VOL:   b = {LATCH_BIT, c.ch, 1'b1, c.data[3:0]};
                KIND_NOISE: b = {LATCH_BIT, REG_NOISE, 1'b0, c.data[2:0]};
                default:    b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/jt89_cmd_writer_if.sv
// Command handshake bundle between a command source and the jt89 command writer.
// Latency: none (wires only).
// Backpressure: source holds cmd_valid and fields until cmd_ready is seen at a rising edge.
// Signals: cmd_valid, cmd_ready, cmd_kind[1:0], cmd_ch[1:0], cmd_data[9:0].
interface jt89_cmd_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [1:0] cmd_ch;
    logic [9:0] cmd_data;

    modport master (
        output cmd_valid, cmd_kind, cmd_ch, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_ch, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/jt89_wr_strobe.sv
// Phase counter and wr_n generator: one or two low/high strobe pulses per start.
// Latency: wr_n is low in the cycle after the start edge; idle returns after 1 or 2 x (WR_LOW+WR_HIGH) cycles.
// Backpressure: start is only honoured while idle; more is sampled at the end of the first high phase.
// Ports: clk, rst (sync, active high), start, more -> wr_n, phase_done, idle.
module jt89_wr_strobe
    import jt89_cmd_pkg::*;
#(
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic more,
    output logic wr_n,
    output logic phase_done,
    output logic idle
);

    localparam logic [3:0] LOW_LAST  = 4'(WR_LOW - 1);
    localparam logic [3:0] HIGH_LAST = 4'(WR_HIGH - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_n_q, wr_n_d;
    logic       in_low;
    logic [3:0] last;

    always_comb begin
        in_low     = (state_q == ST_LOW1) || (state_q == ST_LOW2);
        last       = in_low ? LOW_LAST : HIGH_LAST;
        phase_done = (state_q != ST_IDLE) && (cnt_q == last);

        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        if ((state_q == ST_IDLE) || phase_done) begin
            cnt_d = 4'd0;
        end

        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_LOW1;
            ST_LOW1:  if (phase_done) state_d = ST_HIGH1;
            ST_HIGH1: if (phase_done) state_d = more ? ST_LOW2 : ST_IDLE;
            ST_LOW2:  if (phase_done) state_d = ST_HIGH2;
            ST_HIGH2: if (phase_done) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase

        // Registered from the next state so the strobe leaves a flop cleanly.
        wr_n_d = !((state_d == ST_LOW1) || (state_d == ST_LOW2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
        end
    end

    assign wr_n = wr_n_q;
    assign idle = (state_q == ST_IDLE);

endmodule

// File: rtl/jt89_cmd_writer.sv
// Serialises tone/volume/noise commands into SN76489 byte writes on wr_n/dout (optional shadows: JT89_CMD_SHADOW_EN).
// Latency: wr_n low the cycle after accept; ready again after 1+WR_LOW+WR_HIGH (one byte) or 1+2x that (tone).
// Backpressure: cmd_ready only while the strobe is idle; dropped commands keep cmd_ready high.
// Ports: clk, rst (sync, active high), cmd (slave handshake), wr_n, dout[7:0], busy, err.
module jt89_cmd_writer
    import jt89_cmd_pkg::*;
#(
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1
) (
    input  logic              clk,
    input  logic              rst,
    jt89_cmd_writer_if.slave  cmd,
    output logic              wr_n,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              err
);

    cmd_t       in_cmd;
    cmd_t       cmd_q, cmd_d;
    logic [7:0] dout_q, dout_d;
    logic       more_q, more_d;
    logic       err_q, err_d;

    logic ready;
    logic accept;
    logic illegal;
    logic redundant;
    logic two;
    logic start;
    logic phase_done;
    logic strobe_idle;
    logic strobe_wr_n;

    assign in_cmd  = '{kind: cmd.cmd_kind, ch: cmd.cmd_ch, data: cmd.cmd_data};
    assign ready   = strobe_idle;
    assign accept  = cmd.cmd_valid && ready;
    assign illegal = (in_cmd.kind == KIND_RSVD) ||
                     ((in_cmd.kind == KIND_TONE) && (in_cmd.ch == 2'd3));
    assign start   = accept && !illegal && !redundant;

`ifdef JT89_CMD_SHADOW_EN
    // Mirrors of the PSG registers, reset to the PSG's own reset values.
    logic [3:0][9:0] tone_sh_q, tone_sh_d;
    logic [3:0][3:0] vol_sh_q, vol_sh_d;
    logic [2:0]      ctrl3_q, ctrl3_d;

    always_comb begin
        tone_sh_d = tone_sh_q;
        vol_sh_d  = vol_sh_q;
        ctrl3_d   = ctrl3_q;

        redundant = 1'b0;
        if ((in_cmd.kind == KIND_TONE) && !illegal) begin
            redundant = (tone_sh_q[in_cmd.ch] == in_cmd.data);
        end else if (in_cmd.kind == KIND_VOL) begin
            redundant = (vol_sh_q[in_cmd.ch] == in_cmd.data[3:0]);
        end
        // Noise writes always go out: each one restarts the LFSR.

        // Data byte only needed when the high bits actually change.
        two = (in_cmd.kind == KIND_TONE) &&
              (tone_sh_q[in_cmd.ch][9:4] != in_cmd.data[9:4]);

        if (accept && !illegal) begin
            case (in_cmd.kind)
                KIND_TONE:  tone_sh_d[in_cmd.ch] = in_cmd.data;
                KIND_VOL:   vol_sh_d[in_cmd.ch]  = in_cmd.data[3:0];
                KIND_NOISE: ctrl3_d              = in_cmd.data[2:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_sh_q <= '0;
            vol_sh_q  <= {4{4'hF}};
            ctrl3_q   <= 3'b100;
        end else begin
            tone_sh_q <= tone_sh_d;
            vol_sh_q  <= vol_sh_d;
            ctrl3_q   <= ctrl3_d;
        end
    end
`else
    assign redundant = 1'b0;
    assign two       = (in_cmd.kind == KIND_TONE);
`endif

    always_comb begin
        cmd_d  = cmd_q;
        dout_d = dout_q;
        more_d = more_q;
        err_d  = accept && illegal;

        if (accept) begin
            cmd_d = in_cmd;
        end

        if (start) begin
            dout_d = enc_byte(in_cmd, 1'b0);
            more_d = two;
        end else if (more_q && phase_done && strobe_wr_n) begin
            // End of first high phase with a data byte pending: entering LOW2.
            dout_d = enc_byte(cmd_q, 1'b1);
            more_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q  <= '0;
            dout_q <= 8'h00;
            more_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            dout_q <= dout_d;
            more_q <= more_d;
            err_q  <= err_d;
        end
    end

    jt89_wr_strobe #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .more       (more_q),
        .wr_n       (strobe_wr_n),
        .phase_done (phase_done),
        .idle       (strobe_idle)
    );

    assign cmd.cmd_ready = ready;
    assign wr_n          = strobe_wr_n;
    assign dout          = dout_q;
    assign busy          = !ready;
    assign err           = err_q;

endmodule

// File: tb/tb_jt89_cmd_writer.sv
// Bench for jt89_cmd_writer: default strobe timing on u_dut0, WR_LOW=3/WR_HIGH=2 on u_dut1.
// Expected bytes are queued when commands are driven and popped on each wr_n falling edge.
module tb_jt89_cmd_writer;
    import jt89_cmd_pkg::*;

    localparam int LIM = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jt89_cmd_writer_if bus0();
    jt89_cmd_writer_if bus1();

    logic       wr_n0, busy0, err0, wr_n1, busy1, err1;
    logic [7:0] dout0, dout1;

    jt89_cmd_writer #(.WR_LOW(1), .WR_HIGH(1)) u_dut0 (
        .clk(clk), .rst(rst), .cmd(bus0.slave),
        .wr_n(wr_n0), .dout(dout0), .busy(busy0), .err(err0)
    );

    jt89_cmd_writer #(.WR_LOW(3), .WR_HIGH(2)) u_dut1 (
        .clk(clk), .rst(rst), .cmd(bus1.slave),
        .wr_n(wr_n1), .dout(dout1), .busy(busy1), .err(err1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         fall_cyc0[$];
    int         fall_cyc1[$];
    int         stab0 = 0;
    int         stab1 = 0;

    // Write monitors: byte at each fall, low-phase length, dout stability between falls.
    initial begin
        logic       pw, prst;
        logic [7:0] pd;
        int         low;
        pw = 1'b1; pd = 8'h00; low = 0; prst = 1'b1;
        forever begin
            @(negedge clk);
            if (pw && !wr_n0) begin
                fall_cyc0.push_back(cyc + 1);
                check("wr_queued0", 32'(exp_q0.size() > 0), 1);
                if (exp_q0.size() > 0) check("byte0", dout0, exp_q0.pop_front());
            end else if (!rst && !prst && dout0 !== pd) begin
                stab0++;
            end
            if (!wr_n0) low++;
            else if (!pw) begin
                if (!rst && !prst) check("low_len0", low, 1);
                low = 0;
            end
            pw = wr_n0; pd = dout0; prst = rst;
        end
    end

    initial begin
        logic       pw, prst;
        logic [7:0] pd;
        int         low;
        pw = 1'b1; pd = 8'h00; low = 0; prst = 1'b1;
        forever begin
            @(negedge clk);
            if (pw && !wr_n1) begin
                fall_cyc1.push_back(cyc + 1);
                check("wr_queued1", 32'(exp_q1.size() > 0), 1);
                if (exp_q1.size() > 0) check("byte1", dout1, exp_q1.pop_front());
            end else if (!rst && !prst && dout1 !== pd) begin
                stab1++;
            end
            if (!wr_n1) low++;
            else if (!pw) begin
                if (!rst && !prst) check("low_len1", low, 3);
                low = 0;
            end
            pw = wr_n1; pd = dout1; prst = rst;
        end
    end

    task automatic drive(input int u, input logic v, input logic [1:0] k,
                         input logic [1:0] c, input logic [9:0] d);
        if (u == 0) begin
            bus0.cmd_valid = v; bus0.cmd_kind = k; bus0.cmd_ch = c; bus0.cmd_data = d;
        end else begin
            bus1.cmd_valid = v; bus1.cmd_kind = k; bus1.cmd_ch = c; bus1.cmd_data = d;
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? bus0.cmd_ready : bus1.cmd_ready;
    endfunction

    // Called and returns at a negedge; acc is the index of the accepting edge.
    task automatic send(input int u, input logic [1:0] k, input logic [1:0] c,
                        input logic [9:0] d, output int acc);
        int n;
        n = 0;
        drive(u, 1'b1, k, c, d);
        while (!rdy(u) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < LIM), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        drive(u, 1'b0, 2'($urandom), 2'($urandom), 10'($urandom));
        @(negedge clk);
    endtask

    // Returns the first edge index at which cmd_ready is sampled high.
    task automatic wait_rdy(input int u, output int r);
        int n;
        n = 0;
        while (!rdy(u) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < LIM), 1);
        r = cyc + 1;
    endtask

    task automatic do_reset(input logic chk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_wr_n0", wr_n0, 1);
            check("rst_dout0", dout0, 8'h00);
            check("rst_ready0", bus0.cmd_ready, 1);
            check("rst_busy0", busy0, 0);
            check("rst_err0", err0, 0);
            check("rst_wr_n1", wr_n1, 1);
            check("rst_ready1", bus1.cmd_ready, 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, r, nf;
        drive(0, 1'b0, 2'd0, 2'd0, 10'd0);
        drive(1, 1'b0, 2'd0, 2'd0, 10'd0);
        do_reset(1'b1);

        // Tone ch1 0x2A5: latch then data byte, falls 2 apart, ready back after 5.
        fall_cyc0.delete();
        exp_q0.push_back(8'hA5);
        exp_q0.push_back(8'h2A);
        send(0, KIND_TONE, 2'd1, 10'h2A5, t);
        wait_rdy(0, r);
        check("tone_ready_lat", r - t, 5);
        check("tone_nfall", fall_cyc0.size(), 2);
        if (fall_cyc0.size() >= 2) begin
            check("tone_fall1", fall_cyc0[0] - t, 1);
            check("tone_fall_gap", fall_cyc0[1] - fall_cyc0[0], 2);
        end

        // Volume then noise, valid held: accepts 3 cycles apart.
        exp_q0.push_back(8'hD5);
        exp_q0.push_back(8'hE5);
        send(0, KIND_VOL, 2'd2, 10'h005, t);
        send(0, KIND_NOISE, 2'd3, 10'h005, t2);
        check("b2b_gap", t2 - t, 3);
        wait_rdy(0, r);
        check("noise_ready_lat", r - t2, 3);

        // Stretched strobe: 0x90, low 3 cycles, ready back at t+6.
        fall_cyc1.delete();
        exp_q1.push_back(8'h90);
        send(1, KIND_VOL, 2'd0, 10'h000, t);
        wait_rdy(1, r);
        check("slow_ready_lat", r - t, 6);
        check("slow_nfall", fall_cyc1.size(), 1);
        if (fall_cyc1.size() >= 1) check("slow_fall1", fall_cyc1[0] - t, 1);

        // Illegal commands: err the cycle after accept, no write, ready stays.
        for (int i = 0; i < 2; i++) begin
            nf = fall_cyc0.size();
            if (i == 0) send(0, KIND_TONE, 2'd3, 10'h3FF, t);
            else        send(0, KIND_RSVD, 2'd1, 10'h123, t);
            check("ill_err_pulse", err0, 1);
            check("ill_ready", bus0.cmd_ready, 1);
            check("ill_wr_n", wr_n0, 1);
            @(negedge clk);
            check("ill_err_clear", err0, 0);
            repeat (3) @(negedge clk);
            check("ill_nfall", fall_cyc0.size(), nf);
        end

        do_reset(1'b0);
`ifdef JT89_CMD_SHADOW_EN
        nf = fall_cyc0.size();
        send(0, KIND_VOL, 2'd0, 10'h00F, t);
        check("shd_drop_ready", bus0.cmd_ready, 1);
        check("shd_drop_err", err0, 0);
        repeat (3) @(negedge clk);
        check("shd_drop_nfall", fall_cyc0.size(), nf);
        exp_q0.push_back(8'hA5);
        exp_q0.push_back(8'h2A);
        send(0, KIND_TONE, 2'd1, 10'h2A5, t);
        wait_rdy(0, r);
        exp_q0.push_back(8'hA7);
        send(0, KIND_TONE, 2'd1, 10'h2A7, t);
        wait_rdy(0, r);
        check("shd_tone_lat", r - t, 3);
`else
        exp_q0.push_back(8'h9F);
        send(0, KIND_VOL, 2'd0, 10'h00F, t);
        wait_rdy(0, r);
        check("vol_f_lat", r - t, 3);
        exp_q0.push_back(8'hA5);
        exp_q0.push_back(8'h2A);
        send(0, KIND_TONE, 2'd1, 10'h2A5, t);
        wait_rdy(0, r);
        exp_q0.push_back(8'hA7);
        exp_q0.push_back(8'h2A);
        send(0, KIND_TONE, 2'd1, 10'h2A7, t);
        wait_rdy(0, r);
        check("tone2_lat", r - t, 5);
`endif
        // Noise writes are never suppressed.
        exp_q0.push_back(8'hE4);
        exp_q0.push_back(8'hE4);
        send(0, KIND_NOISE, 2'd0, 10'h004, t);
        send(0, KIND_NOISE, 2'd0, 10'h004, t2);
        wait_rdy(0, r);
        check("noise_rep_gap", t2 - t, 3);

        // Reset during LOW2 of a tone write.
        exp_q0.push_back(8'h83);
        exp_q0.push_back(8'h12);
        send(0, KIND_TONE, 2'd0, 10'h123, t);
        repeat (2) @(negedge clk);
        check("low2_wr_n", wr_n0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_n", wr_n0, 1);
        check("mid_rst_dout", dout0, 8'h00);
        check("mid_rst_ready", bus0.cmd_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        nf = fall_cyc0.size();
        repeat (8) @(negedge clk);
        check("mid_rst_nfall", fall_cyc0.size(), nf);

        check("exp_q0_empty", exp_q0.size(), 0);
        check("exp_q1_empty", exp_q1.size(), 0);
        check("dout_stable0", stab0, 0);
        check("dout_stable1", stab1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
